// File: rtl/mem_access_unit.sv
// MEM-stage byte-serial load/store engine over a byte-wide RAM port, little-endian.
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of performing them.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       opcode_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              bus_busy_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              mem_busy_o,
  output logic              stall_req_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              misalign_o
);

  typedef enum logic [2:0] {IDLE, WAIT, RD, RD_LAST, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] asm_q;
  logic [1:0]  rd_idx;
  logic [6:0]  major;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem, bad_ls, misal, last;
  logic [2:0]  nbytes;
  logic [31:0] load_val;
  logic        unused_f7;

  assign major     = opcode_i[6:0];
  assign funct3    = opcode_i[9:7];
  assign unused_f7 = opcode_i[10];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    nbytes   = 3'd1;
    if (major == 7'b0000011) begin
      case (funct3)
        3'b000, 3'b100: begin is_load = 1'b1; nbytes = 3'd1; end
        3'b001, 3'b101: begin is_load = 1'b1; nbytes = 3'd2; end
        3'b010:         begin is_load = 1'b1; nbytes = 3'd4; end
        default: ;
      endcase
    end else if (major == 7'b0100011) begin
      case (funct3)
        3'b000:  begin is_store = 1'b1; nbytes = 3'd1; end
        3'b001:  begin is_store = 1'b1; nbytes = 3'd2; end
        3'b010:  begin is_store = 1'b1; nbytes = 3'd4; end
        default: ;
      endcase
    end
  end

  assign is_mem = is_load | is_store;
  assign bad_ls = ((major == 7'b0000011) || (major == 7'b0100011)) && !is_mem;
  assign last   = (cnt_q == nbytes - 3'd1);
  // Byte arriving now was issued last cycle; in RD_LAST cnt_q == N so this wraps to N-1.
  assign rd_idx = cnt_q[1:0] - 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = is_mem && (((nbytes == 3'd2) && mem_addr_i[0]) ||
                            ((nbytes == 3'd4) && (mem_addr_i[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    case (funct3)
      3'b000:  load_val = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  load_val = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  load_val = {24'b0, asm_q[7:0]};
      3'b101:  load_val = {16'b0, asm_q[15:0]};
      default: load_val = asm_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, WAIT: begin
          cnt_q <= '0;
          asm_q <= '0;
        end
        RD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q != 3'd0) asm_q[{rd_idx, 3'b000} +: 8] <= mem_din_i;
        end
        RD_LAST: asm_q[{rd_idx, 3'b000} +: 8] <= mem_din_i;
        WR:      cnt_q <= cnt_q + 3'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (misal)           state_d = DONE;
          else if (bus_busy_i) state_d = WAIT;
          else                 state_d = is_load ? RD : WR;
        end
      end
      WAIT:    if (!bus_busy_i) state_d = is_load ? RD : WR;
      RD:      if (last) state_d = RD_LAST;
      RD_LAST: state_d = DONE;
      WR:      if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced to zero while rst is high so a reset clears them immediately.
  always_comb begin
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    mem_busy_o  = 1'b0;
    stall_req_o = 1'b0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    misalign_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          wd_o = wd_i;
          if (is_mem) begin
            stall_req_o = 1'b1;
          end else begin
            wreg_o  = wreg_i & ~bad_ls;
            wdata_o = wdata_i;
          end
        end
        WAIT: stall_req_o = 1'b1;
        RD: begin
          mem_a_o     = ADDR_W'(mem_addr_i + 32'(cnt_q));
          mem_busy_o  = 1'b1;
          stall_req_o = 1'b1;
        end
        RD_LAST: begin
          mem_busy_o  = 1'b1;
          stall_req_o = 1'b1;
        end
        WR: begin
          mem_a_o     = ADDR_W'(mem_addr_i + 32'(cnt_q));
          mem_dout_o  = wdata_i[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_o    = 1'b1;
          mem_busy_o  = 1'b1;
          stall_req_o = 1'b1;
        end
        default: begin
          wd_o       = wd_i;
          wreg_o     = wreg_i & is_load & ~misal;
          wdata_o    = load_val;
          misalign_o = misal;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte RAM model, expected writes/results queued by
// the stimulus and checked by a negedge monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode_i;
  logic [31:0] mem_addr_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, bus_busy_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o, mem_busy_o, stall_req_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .mem_addr_i(mem_addr_i), .wdata_i(wdata_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .bus_busy_i(bus_busy_i), .mem_din_i(mem_din_i),
    .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_busy_o(mem_busy_o),
    .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  typedef struct {
    string       nm;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        mis;
    int          stalls;
  } exp_t;

  exp_t        rq[$];
  logic [39:0] wq[$];
  int          total = 0;
  int          bad = 0;
  int          scnt = 0;
  logic        tb_valid = 1'b0;
  logic        ram_clr = 1'b1;
  logic [7:0]  ram [0:4095];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (!rst && mem_wr_o) begin
      ram[mem_a_o[11:0]] <= mem_dout_o;
    end
    mem_din_i <= ram[mem_a_o[11:0]];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic exp_res(input string nm, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic mis, input int stalls);
    exp_t e;
    e.nm = nm; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.mis = mis; e.stalls = stalls;
    rq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_o) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=%h/%h required=none", mem_a_o, mem_dout_o);
        end else begin
          check("ram_write", {24'b0, mem_a_o, mem_dout_o}, {24'b0, wq.pop_front()});
        end
      end
      if (tb_valid) begin
        if (stall_req_o) begin
          scnt++;
        end else if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual=%h required=none", wdata_o);
        end else begin
          exp_t e;
          e = rq.pop_front();
          check({e.nm, "_res"}, {25'b0, wd_o, wreg_o, wdata_o, misalign_o},
                {25'b0, e.wd, e.wreg, e.wdata, e.mis});
          check({e.nm, "_stalls"}, 64'(scnt), 64'(e.stalls));
          check({e.nm, "_busy"}, {63'b0, mem_busy_o}, 64'd0);
          scnt = 0;
        end
      end
    end
  end

  task automatic idle_inputs();
    opcode_i = '0; mem_addr_i = '0; wdata_i = '0; wd_i = '0; wreg_i = 1'b0; bus_busy_i = 1'b0;
  endtask

  task automatic run_op(input logic [6:0] major, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] wd, input int busy);
    int n;
    opcode_i = {1'b0, f3, major}; mem_addr_i = a; wdata_i = d; wd_i = wd; wreg_i = 1'b1;
    bus_busy_i = (busy > 0);
    scnt = 0;
    tb_valid = 1'b1;
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      check("wait_no_access", {62'b0, mem_busy_o, mem_wr_o}, 64'd0);
      @(posedge clk); #1;
    end
    bus_busy_i = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!stall_req_o) break;
    end
    if (n == 50) begin
      total++; bad++;
      $display("FAIL op_timeout actual=stalled required=done");
    end
    @(posedge clk); #1;
    tb_valid = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", {21'b0, mem_a_o, mem_dout_o, mem_wr_o, mem_busy_o, stall_req_o}, 64'd0);
    check("reset_wb", {25'b0, wd_o, wreg_o, wdata_o, misalign_o}, 64'd0);
    ram_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    wq.push_back({32'h100, 8'hEF}); wq.push_back({32'h101, 8'hBE});
    wq.push_back({32'h102, 8'hAD}); wq.push_back({32'h103, 8'hDE});
    exp_res("sw", 5'd9, 1'b0, 32'h0, 1'b0, 5);
    run_op(STORE, 3'b010, 32'h100, 32'hDEADBEEF, 5'd9, 0);

    exp_res("lb", 5'd5, 1'b1, 32'hFFFFFFEF, 1'b0, 3);
    run_op(LOAD, 3'b000, 32'h100, 32'h0, 5'd5, 0);
    exp_res("lbu", 5'd6, 1'b1, 32'h000000EF, 1'b0, 3);
    run_op(LOAD, 3'b100, 32'h100, 32'h0, 5'd6, 0);
    exp_res("lw", 5'd7, 1'b1, 32'hDEADBEEF, 1'b0, 6);
    run_op(LOAD, 3'b010, 32'h100, 32'h0, 5'd7, 0);
    exp_res("lh_wait", 5'd8, 1'b1, 32'hFFFFDEAD, 1'b0, 7);
    run_op(LOAD, 3'b001, 32'h102, 32'h0, 5'd8, 3);
    exp_res("lhu", 5'd10, 1'b1, 32'h0000BEEF, 1'b0, 4);
    run_op(LOAD, 3'b101, 32'h100, 32'h0, 5'd10, 0);

    exp_res("add", 5'd3, 1'b1, 32'h1234, 1'b0, 0);
    run_op(ALU, 3'b000, 32'h0, 32'h1234, 5'd3, 0);
    exp_res("bad_f3", 5'd4, 1'b0, 32'hCAFE, 1'b0, 0);
    run_op(LOAD, 3'b011, 32'h100, 32'hCAFE, 5'd4, 0);

    wq.push_back({32'h300, 8'hA5});
    exp_res("sb", 5'd11, 1'b0, 32'h0, 1'b0, 2);
    run_op(STORE, 3'b000, 32'h300, 32'h123456A5, 5'd11, 0);
    exp_res("lb_neg", 5'd12, 1'b1, 32'hFFFFFFA5, 1'b0, 3);
    run_op(LOAD, 3'b000, 32'h300, 32'h0, 5'd12, 0);

`ifdef MEM_ALIGN_CHECK_EN
    exp_res("lw_misal", 5'd13, 1'b0, 32'h0, 1'b1, 1);
    run_op(LOAD, 3'b010, 32'h102, 32'h0, 5'd13, 0);
    exp_res("sh_misal", 5'd14, 1'b0, 32'h0, 1'b1, 1);
    run_op(STORE, 3'b001, 32'hFFFFFFFF, 32'h7788, 5'd14, 0);
`else
    exp_res("lw_unaligned", 5'd13, 1'b1, 32'h0000DEAD, 1'b0, 6);
    run_op(LOAD, 3'b010, 32'h102, 32'h0, 5'd13, 0);
    wq.push_back({32'hFFFFFFFF, 8'h88}); wq.push_back({32'h00000000, 8'h77});
    exp_res("sh_wrap", 5'd14, 1'b0, 32'h0, 1'b0, 3);
    run_op(STORE, 3'b001, 32'hFFFFFFFF, 32'h7788, 5'd14, 0);
    exp_res("lhu_wrap", 5'd15, 1'b1, 32'h00007788, 1'b0, 4);
    run_op(LOAD, 3'b101, 32'hFFFFFFFF, 32'h0, 5'd15, 0);
`endif

    // Reset during the second byte of a word store.
    wq.push_back({32'h200, 8'h44});
    opcode_i = {1'b0, 3'b010, STORE}; mem_addr_i = 32'h200; wdata_i = 32'h11223344;
    wd_i = 5'd2; wreg_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_bus", {21'b0, mem_a_o, mem_dout_o, mem_wr_o, mem_busy_o, stall_req_o}, 64'd0);
    check("midrst_wb", {25'b0, wd_o, wreg_o, wdata_o, misalign_o}, 64'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_byte0", {56'b0, ram[12'h200]}, 64'h44);
    check("midrst_byte1", {56'b0, ram[12'h201]}, 64'h00);

    exp_res("add_after_rst", 5'd1, 1'b1, 32'h5A5A, 1'b0, 0);
    run_op(ALU, 3'b000, 32'h0, 32'h5A5A, 5'd1, 0);

    repeat (2) @(posedge clk);
    check("writes_drained", 64'(wq.size()), 64'd0);
    check("results_drained", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
